// File: rtl/sha256_msg_schedule_if.sv
// Block-in / schedule-word-out bus between the SHA-256 message schedule and
// its environment (block source and round datapath).
interface sha256_msg_schedule_if;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic [31:0]  w_out;
  logic [5:0]   w_select;
  logic         w_valid;
  logic         w_ready;
  logic         w_last;
  logic         busy;

  modport master (
    input  blk_valid, blk_data, w_ready,
    output blk_ready, w_out, w_select, w_valid, w_last, busy
  );

  modport slave (
    output blk_valid, blk_data, w_ready,
    input  blk_ready, w_out, w_select, w_valid, w_last, busy
  );
endinterface

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads a 512-bit block into a 16-word window and
// streams W0..W(ROUNDS-1) with their round index over a valid/ready handshake.
module sha256_msg_schedule #(
  parameter int ROUNDS = 64
) (
  input logic                  clk,
  input logic                  rst,
  sha256_msg_schedule_if.master bus
);

  localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] win_r [16];
  logic [5:0]  t_r;
  logic        last_r;
  logic        accept_s;
  logic        fire_s;
  logic [31:0] w_new_s;
  logic        blk_ready_s;
  logic        w_valid_s;
  logic        busy_s;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 5'd3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 5'd10);
  endfunction

  assign accept_s = (state_r == IDLE) && bus.blk_valid;
  assign fire_s   = (state_r == RUN) && bus.w_ready;
  // Expansion uses the pre-shift window: win[0] is W[t], so win[15] becomes W[t+16].
  assign w_new_s  = sig1(win_r[14]) + win_r[9] + sig0(win_r[1]) + win_r[0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = RUN;
        else          state_nxt_s = IDLE;
      end
      RUN: begin
        if (fire_s && last_r) state_nxt_s = IDLE;
        else                  state_nxt_s = RUN;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    blk_ready_s = 1'b1;
    w_valid_s   = 1'b0;
    busy_s      = 1'b0;
    case (state_r)
      IDLE: begin
        blk_ready_s = 1'b1;
        w_valid_s   = 1'b0;
        busy_s      = 1'b0;
      end
      RUN: begin
        blk_ready_s = 1'b0;
        w_valid_s   = 1'b1;
        busy_s      = 1'b1;
      end
      default: begin
        blk_ready_s = 1'b1;
        w_valid_s   = 1'b0;
        busy_s      = 1'b0;
      end
    endcase
  end

  // Sliding window, round index and last flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) win_r[i] <= 32'd0;
      t_r    <= 6'd0;
      last_r <= 1'b0;
    end else if (accept_s) begin
      for (int i = 0; i < 16; i++) win_r[i] <= bus.blk_data[32*(15-i) +: 32];
      t_r    <= 6'd0;
      last_r <= (LAST_T == 6'd0);
    end else if (fire_s && !last_r) begin
      for (int i = 0; i < 15; i++) win_r[i] <= win_r[i+1];
      win_r[15] <= w_new_s;
      t_r       <= t_r + 6'd1;
      last_r    <= ((t_r + 6'd1) == LAST_T);
    end else if (fire_s) begin
      // Final word consumed: park the index so w_last cannot linger in IDLE.
      t_r    <= 6'd0;
      last_r <= 1'b0;
    end
  end

  assign bus.w_out     = win_r[0];
  assign bus.w_select  = t_r;
  assign bus.w_last    = last_r;
  assign bus.w_valid   = w_valid_s;
  assign bus.blk_ready = blk_ready_s;
  assign bus.busy      = busy_s;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Bench for sha256_msg_schedule: directed and random blocks compared against
// a textbook SHA-256 schedule expansion; covers stalls, back-to-back, reset, ROUNDS=16.
module tb_sha256_msg_schedule;

  logic         clk = 1'b0;
  logic         rst;
  logic         sel;
  logic         blk_valid;
  logic         w_ready;
  logic [511:0] blk_data;
  int           checks = 0;
  int           errors = 0;
  logic [31:0]  exp_w [64];
  logic [31:0]  got_w [64];
  logic [511:0] abc_blk;
  logic [511:0] r1;
  logic [511:0] r2;

  always #5 clk = ~clk;

  sha256_msg_schedule_if b64 ();
  sha256_msg_schedule_if b16 ();

  assign b64.blk_valid = blk_valid & ~sel;
  assign b16.blk_valid = blk_valid & sel;
  assign b64.blk_data  = blk_data;
  assign b16.blk_data  = blk_data;
  assign b64.w_ready   = w_ready & ~sel;
  assign b16.w_ready   = w_ready & sel;

  sha256_msg_schedule #(.ROUNDS(64)) dut64 (.clk(clk), .rst(rst), .bus(b64));
  sha256_msg_schedule #(.ROUNDS(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));

  wire [31:0] o_w_out     = sel ? b16.w_out     : b64.w_out;
  wire [5:0]  o_w_select  = sel ? b16.w_select  : b64.w_select;
  wire        o_w_valid   = sel ? b16.w_valid   : b64.w_valid;
  wire        o_w_last    = sel ? b16.w_last    : b64.w_last;
  wire        o_blk_ready = sel ? b16.blk_ready : b64.blk_ready;
  wire        o_busy      = sel ? b16.busy      : b64.busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Standard schedule recurrence over the whole 64-entry array.
  function automatic void build_ref(input logic [511:0] blk);
    for (int i = 0; i < 16; i++) exp_w[i] = blk[32*(15-i) +: 32];
    for (int i = 16; i < 64; i++)
      exp_w[i] = ssig1(exp_w[i-2]) + exp_w[i-7] + ssig0(exp_w[i-15]) + exp_w[i-16];
  endfunction

  function automatic logic [511:0] rand_blk();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // mode 0: ready always, 1: ready 1,0,0 pattern, 2: random ready
  task automatic run_block(input logic [511:0] blk, input int mode, input int rounds,
                           input bit hold, input logic [511:0] next_blk, input int abort_at);
    int idx;
    int cyc;
    build_ref(blk);
    blk_valid = 1'b1;
    blk_data  = blk;
    chk("blk_ready_idle", {31'd0, o_blk_ready}, 32'd1);
    @(posedge clk); #1;
    blk_valid = hold;
    blk_data  = rand_blk();
    idx = 0;
    cyc = 0;
    while (idx < rounds && cyc < 4 * rounds + 8) begin
      if (abort_at >= 0 && idx == abort_at) begin
        w_ready = 1'b0;
        rst = 1'b1;
        #2;
        chk("rst_w_valid", {31'd0, o_w_valid}, 32'd0);
        chk("rst_blk_ready", {31'd0, o_blk_ready}, 32'd1);
        chk("rst_w_select", {26'd0, o_w_select}, 32'd0);
        chk("rst_w_out", o_w_out, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        #1;
        rst = 1'b0;
        blk_valid = 1'b0;
        return;
      end
      case (mode)
        0:       w_ready = 1'b1;
        1:       w_ready = (cyc % 3 == 0);
        default: w_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      chk("w_valid", {31'd0, o_w_valid}, 32'd1);
      chk("w_select", {26'd0, o_w_select}, 32'(idx));
      chk("w_out", o_w_out, exp_w[idx]);
      chk("w_last", {31'd0, o_w_last}, {31'd0, (idx == rounds - 1)});
      chk("busy", {31'd0, o_busy}, 32'd1);
      chk("blk_ready_run", {31'd0, o_blk_ready}, 32'd0);
      if (w_ready) begin
        got_w[idx] = o_w_out;
        idx++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    w_ready = 1'b0;
    if (hold) blk_data = next_blk;
    else      blk_valid = 1'b0;
    chk("word_count", 32'(idx), 32'(rounds));
    if (mode == 0) chk("cycle_count", 32'(cyc), 32'(rounds));
    @(negedge clk);
    chk("end_w_valid", {31'd0, o_w_valid}, 32'd0);
    chk("end_blk_ready", {31'd0, o_blk_ready}, 32'd1);
    chk("end_busy", {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    abc_blk = 512'd0;
    abc_blk[511:480] = 32'h61626380;
    abc_blk[31:0]    = 32'h00000018;
    sel = 1'b0;
    rst = 1'b1;
    blk_valid = 1'b0;
    w_ready = 1'b0;
    blk_data = 512'd0;

    // Reset values, including w_ready asserted with nothing valid
    repeat (2) @(posedge clk);
    #1;
    w_ready = 1'b1;
    chk("reset_blk_ready", {31'd0, o_blk_ready}, 32'd1);
    chk("reset_w_valid", {31'd0, o_w_valid}, 32'd0);
    chk("reset_w_last", {31'd0, o_w_last}, 32'd0);
    chk("reset_busy", {31'd0, o_busy}, 32'd0);
    chk("reset_w_out", o_w_out, 32'd0);
    chk("reset_w_select", {26'd0, o_w_select}, 32'd0);
    #3;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_ready_noeffect_valid", {31'd0, o_w_valid}, 32'd0);
    chk("idle_ready_noeffect_sel", {26'd0, o_w_select}, 32'd0);
    w_ready = 1'b0;

    // "abc" block, ready held high, with known schedule values
    run_block(abc_blk, 0, 64, 1'b0, 512'd0, -1);
    chk("abc_W0", got_w[0], 32'h61626380);
    chk("abc_W15", got_w[15], 32'h00000018);
    chk("abc_W16", got_w[16], 32'h61626380);
    chk("abc_W17", got_w[17], 32'h000F0000);
    chk("abc_W63", got_w[63], 32'h12B1EDEB);

    run_block(512'd0, 0, 64, 1'b0, 512'd0, -1);
    run_block(abc_blk, 1, 64, 1'b0, 512'd0, -1);
    chk("stall_abc_W63", got_w[63], 32'h12B1EDEB);

    // Back-to-back with blk_valid held and blk_data scrambled during RUN
    r1 = rand_blk();
    r2 = rand_blk();
    run_block(r1, 0, 64, 1'b1, r2, -1);
    run_block(r2, 2, 64, 1'b0, 512'd0, -1);

    // Reset at t=20, then a clean restart
    run_block(abc_blk, 0, 64, 1'b0, 512'd0, 20);
    run_block(abc_blk, 0, 64, 1'b0, 512'd0, -1);

    for (int k = 0; k < 2; k++) run_block(rand_blk(), 2, 64, 1'b0, 512'd0, -1);

    // ROUNDS=16 instance
    sel = 1'b1;
    @(posedge clk); #1;
    run_block(abc_blk, 0, 16, 1'b0, 512'd0, -1);
    chk("r16_W15", got_w[15], 32'h00000018);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
